// File: rtl/scan_sel_ctrl.sv
// scan_sel_ctrl: select/enable sequencer for a 3-to-8 decoder.
// Scans a latched channel mask with a programmable dwell and a blanking gap.
module scan_sel_ctrl #(
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [7:0]         ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               en,
    output logic               busy,
    output logic               sweep_done
);
    localparam int BW = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_t;

    state_t             state, state_n;
    logic [2:0]         sel_n;
    logic [DWELL_W-1:0] dcnt, dcnt_n, dwell_q, dwell_n;
    logic [BW-1:0]      bcnt, bcnt_n;
    logic [7:0]         mask_q, mask_n;
    logic               mode_q, mode_n, done_n, adv;

    function automatic logic [2:0] lowest(input logic [7:0] m);
        lowest = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) lowest = 3'(i);
    endfunction

    function automatic logic [2:0] above(input logic [7:0] m, input logic [2:0] s);
        above = lowest(m);
        for (int i = 7; i >= 0; i--)
            if (m[i] && i > int'(s)) above = 3'(i);
    endfunction

    function automatic logic last(input logic [7:0] m, input logic [2:0] s);
        last = ((m >> s) >> 1) == 8'd0;
    endfunction

    always_comb begin
        state_n = state;
        sel_n   = sel;
        dcnt_n  = dcnt;
        bcnt_n  = bcnt;
        mask_n  = mask_q;
        dwell_n = dwell_q;
        mode_n  = mode_q;
        adv     = 1'b0;
        case (state)
            IDLE: if (start && !stop && ch_mask != 8'd0) begin
                state_n = DRIVE;
                mask_n  = ch_mask;
                dwell_n = dwell == '0 ? DWELL_W'(1) : dwell;
                mode_n  = mode;
                sel_n   = lowest(ch_mask);
                dcnt_n  = dwell_n - DWELL_W'(1);
            end
            DRIVE: if (dcnt != '0) dcnt_n = dcnt - DWELL_W'(1);
                   else if (BLANK_CYCLES == 0) adv = 1'b1;
                   else begin
                       state_n = BLANK;
                       bcnt_n  = BW'(BLANK_CYCLES - 1);
                   end
            BLANK: if (bcnt != '0) bcnt_n = bcnt - BW'(1);
                   else adv = 1'b1;
            default: state_n = IDLE;
        endcase
        if (adv) begin
            if (last(mask_q, sel) && mode_q) state_n = IDLE;
            else begin
                state_n = DRIVE;
                sel_n   = above(mask_q, sel);
                dcnt_n  = dwell_q - DWELL_W'(1);
            end
        end
        // stop outranks both a pending start and a coincident end-of-sweep
        if (stop && state != IDLE) begin
            state_n = IDLE;
            sel_n   = sel;
        end
        done_n = state_n == BLANK ? (bcnt_n == '0 && last(mask_n, sel_n))
               : (BLANK_CYCLES == 0 && state_n == DRIVE && dcnt_n == '0 && last(mask_n, sel_n));
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= IDLE;
            sel        <= 3'd0;
            en         <= 1'b0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
            dcnt       <= '0;
            bcnt       <= '0;
            mask_q     <= 8'd0;
            dwell_q    <= '0;
            mode_q     <= 1'b0;
        end else begin
            state      <= state_n;
            sel        <= sel_n;
            en         <= state_n == DRIVE;
            busy       <= state_n != IDLE;
            sweep_done <= done_n;
            dcnt       <= dcnt_n;
            bcnt       <= bcnt_n;
            mask_q     <= mask_n;
            dwell_q    <= dwell_n;
            mode_q     <= mode_n;
        end
endmodule

// File: doc/scan_sel_ctrl.md
Name: scan_sel_ctrl

Overview:
- Sequencer that sits directly upstream of the team's 3-to-8 enabled decoder.
- Generates the 3-bit select and the enable that the decoder consumes.
- Steps through a programmable subset of the 8 channels with a programmable dwell time, and inserts a blanking gap (enable low) between channels.
- Supports single-sweep and continuous scanning for row/LED multiplex drive.

Parameters:
- DWELL_W, 8, width of the dwell-count input.
- BLANK_CYCLES, 2, number of enable-low cycles between channels; 0 means no gap.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin scanning.
- stop  input  1  one-cycle request to abort scanning.
- mode  input  1  0 = continuous, 1 = single sweep.
- ch_mask  input  8  bit i set means channel i is scanned.
- dwell  input  DWELL_W  enable-high cycles per channel; 0 is treated as 1.
- sel  output  3  channel index to the decoder's select input.
- en  output  1  decoder enable.
- busy  output  1  high while scanning.
- sweep_done  output  1  one-cycle pulse when a full pass over the enabled channels completes.

Behaviour:
- Clocking and reset (already decided):
  - One clock, clk.
  - rst is asynchronous and active-high.
  - On rst: state IDLE, sel=0, en=0, busy=0, sweep_done=0, dwell/blank counters=0, latched config=0.
  - Reset asserted mid-operation clears all outputs immediately, without waiting for a clock edge.
- All outputs are registered. en is never combinational from inputs.
- FSM states: IDLE, DRIVE, BLANK.
- IDLE:
  - start=1 and ch_mask!=0 and stop=0: latch ch_mask, max(dwell,1) and mode.
  - Next cycle: DRIVE, sel = lowest set bit of the mask, en=1, busy=1. Latency is one clock from start to en.
  - start with ch_mask==0 is ignored: stays IDLE, no pulse.
- DRIVE:
  - en=1 for exactly D = max(latched dwell,1) consecutive cycles; sel is constant throughout.
  - Then BLANK, or, if BLANK_CYCLES==0, directly the next channel's DRIVE.
- BLANK:
  - en=0 for exactly BLANK_CYCLES cycles.
  - sel holds the previous channel, so the decoder sees a stable select when disabled.
- Next-channel selection:
  - Next set bit of the latched mask strictly above the current sel.
  - If none exists, wrap to the lowest set bit; this is end-of-sweep.
  - A single-bit mask wraps to itself every pass.
- End-of-sweep:
  - sweep_done=1 for one cycle, coincident with the final BLANK cycle of the last channel (the final DRIVE cycle when BLANK_CYCLES==0).
  - mode=1: next state IDLE; en=0 and busy=0 from the following cycle; sel holds.
  - mode=0: continue with the lowest set bit's DRIVE.
- stop:
  - Honoured in any busy state: next cycle IDLE, en=0, busy=0, sel holds, no sweep_done.
  - stop has priority over start and over a coincident end-of-sweep.
- start while busy is ignored.
- ch_mask, dwell and mode changes while busy are ignored until the next accepted start.
- Dwell counting uses a DWELL_W-bit down-counter. The full-scale dwell value is legal and gives 2^DWELL_W-1 cycles without overflow.
- Invariant: en=1 only in DRIVE. The decoder output is therefore one-hot only during dwell and all-zero otherwise.

Test Plan:
- Single sweep, timing: BLANK_CYCLES=2, mode=1, ch_mask=8'b1010_0101, dwell=3, start pulse.
  - sel sequence is 0,2,5,7, each with en high for 3 cycles then low for 2.
  - sweep_done pulses once on the 20th cycle after start.
  - busy falls on the 21st cycle; no further en.
- Continuous, single channel: mode=0, ch_mask=8'h80, dwell=0.
  - sel=7 throughout, en pattern 1,0,0 repeating.
  - sweep_done pulses every 3 cycles, on each final blank cycle.
- Empty mask: start with ch_mask=8'h00 -> busy, en, sel and sweep_done all stay 0.
- Stop priority: stop asserted during BLANK of channel 2, with start asserted the same cycle.
  - Next cycle: IDLE, en=0, busy=0, sel=2, no sweep_done.
  - The start is not accepted.
- Config isolation: change ch_mask 8'h0F->8'hF0 and dwell 3->9 mid-sweep.
  - Sequence stays 0,1,2,3 with 3-cycle dwell until the next start.
- Async reset mid-DRIVE (sel=5, en=1): assert rst between clock edges.
  - sel=0, en=0, busy=0 immediately.
  - After release, IDLE until a new start.
